// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 64-bit add/sltu ALU between two requesters.
// The result is registered and held until the owning port accepts it.
module alu_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_src1,
  input  logic [WIDTH-1:0] req0_src2,
  input  logic [1:0]       req0_aluop,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_src1,
  input  logic [WIDTH-1:0] req1_src2,
  input  logic [1:0]       req1_aluop,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             own_q, own_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             rsp_fire;
  logic             free;
  logic             grant0, grant1;
  logic             fire0, fire1;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] add_res, sltu_res, alu_res;

  // Arbitration: a lone valid port wins; on contention the port not granted last wins.
  always_comb begin
    rsp_fire   = (state_q == HOLD) && (own_q ? rsp1_ready : rsp0_ready);
    free       = (state_q == IDLE) || rsp_fire;
    grant0     = req0_valid && (!req1_valid || last_q);
    grant1     = req1_valid && (!req0_valid || !last_q);
    req0_ready = free && grant0;
    req1_ready = free && grant1;
    fire0      = req0_valid && req0_ready;
    fire1      = req1_valid && req1_ready;
  end

  // Shared ALU, steered by the granted port; op bits are OR-merged.
  always_comb begin
    alu_a    = grant1 ? req1_src1  : req0_src1;
    alu_b    = grant1 ? req1_src2  : req0_src2;
    alu_op   = grant1 ? req1_aluop : req0_aluop;
    add_res  = alu_a + alu_b;
    sltu_res = {{(WIDTH-1){1'b0}}, (alu_a < alu_b)};
    alu_res  = (alu_op[0] ? add_res : '0) | (alu_op[1] ? sltu_res : '0);
  end

  always_comb begin
    state_d  = state_q;
    own_d    = own_q;
    last_d   = last_q;
    result_d = result_q;
    if (fire0 || fire1) begin
      state_d  = HOLD;
      own_d    = fire1;
      last_d   = fire1;
      result_d = alu_res;
    end else if (rsp_fire) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      own_q    <= 1'b0;
      last_q   <= 1'b1;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      own_q    <= own_d;
      last_q   <= last_d;
      result_q <= result_d;
    end
  end

  assign rsp0_valid = (state_q == HOLD) && !own_q;
  assign rsp1_valid = (state_q == HOLD) && own_q;
  assign rsp_result = result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter: single ops, wrap/sltu,
// round-robin contention, backpressure, async reset and odd aluop values.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [63:0] req0_src1, req0_src2;
  logic [1:0]  req0_aluop;
  logic        req1_valid, req1_ready;
  logic [63:0] req1_src1, req1_src2;
  logic [1:0]  req1_aluop;
  logic        rsp0_valid, rsp0_ready;
  logic        rsp1_valid, rsp1_ready;
  logic [63:0] rsp_result;

  int n_checks;
  int n_fail;

  logic [63:0] p0_s1 [2];
  logic [63:0] p0_s2 [2];
  logic [1:0]  p0_op [2];
  logic [63:0] p0_ex [2];
  logic [63:0] p1_s1 [2];
  logic [63:0] p1_s2 [2];
  logic [1:0]  p1_op [2];
  logic [63:0] p1_ex [2];
  int          i0, i1, g;
  logic [63:0] exp_res;

  alu_arbiter #(.WIDTH(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_src1  (req0_src1),
    .req0_src2  (req0_src2),
    .req0_aluop (req0_aluop),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_src1  (req1_src1),
    .req1_src2  (req1_src2),
    .req1_aluop (req1_aluop),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_result (rsp_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [63:0] a, input logic [63:0] b, input logic [1:0] op);
    req0_valid = v;
    req0_src1  = a;
    req0_src2  = b;
    req0_aluop = op;
  endtask

  task automatic set1(input logic v, input logic [63:0] a, input logic [63:0] b, input logic [1:0] op);
    req1_valid = v;
    req1_src1  = a;
    req1_src2  = b;
    req1_aluop = op;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    set0(1'b0, 64'd0, 64'd0, 2'b00);
    set1(1'b0, 64'd0, 64'd0, 2'b00);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;

    #12;
    check("reset_rsp0_valid", rsp0_valid, 0);
    check("reset_rsp1_valid", rsp1_valid, 0);
    check("reset_result", rsp_result, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single add on port 0
    set0(1'b1, 64'd5, 64'd7, 2'b01);
    rsp0_ready = 1'b1;
    #1;
    check("add_req0_ready", req0_ready, 1);
    check("add_req1_ready", req1_ready, 0);
    check("add_rsp1_valid_c0", rsp1_valid, 0);
    tick();
    check("add_rsp0_valid", rsp0_valid, 1);
    check("add_result", rsp_result, 64'd12);
    check("add_rsp1_valid_c1", rsp1_valid, 0);
    req0_valid = 1'b0;
    tick();
    check("add_idle_rsp0_valid", rsp0_valid, 0);

    // Wrap-around add, sltu and odd aluop on port 1, back to back
    rsp1_ready = 1'b1;
    set1(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b01);
    #1;
    check("wrap_req1_ready", req1_ready, 1);
    tick();
    check("wrap_rsp1_valid", rsp1_valid, 1);
    check("wrap_rsp0_valid", rsp0_valid, 0);
    check("wrap_result", rsp_result, 64'd0);
    set1(1'b1, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10);
    #1;
    check("sltu_req1_ready_b2b", req1_ready, 1);
    tick();
    check("sltu_lt_result", rsp_result, 64'd1);
    set1(1'b1, 64'd9, 64'd9, 2'b10);
    tick();
    check("sltu_eq_result", rsp_result, 64'd0);
    set1(1'b1, 64'd5, 64'd7, 2'b00);
    tick();
    check("aluop00_result", rsp_result, 64'd0);
    set1(1'b1, 64'd2, 64'd3, 2'b11);
    tick();
    check("aluop11_result", rsp_result, 64'd5);
    check("aluop11_rsp1_valid", rsp1_valid, 1);
    req1_valid = 1'b0;
    tick();
    check("port1_idle_rsp1_valid", rsp1_valid, 0);

    // Contention: both ports valid, grants must alternate 0,1,0,1
    p0_s1[0] = 64'd10; p0_s2[0] = 64'd20;  p0_op[0] = 2'b01; p0_ex[0] = 64'd30;
    p0_s1[1] = 64'd7;  p0_s2[1] = 64'd8;   p0_op[1] = 2'b01; p0_ex[1] = 64'd15;
    p1_s1[0] = 64'd1;  p1_s2[0] = 64'd100; p1_op[0] = 2'b10; p1_ex[0] = 64'd1;
    p1_s1[1] = 64'd50; p1_s2[1] = 64'd60;  p1_op[1] = 2'b01; p1_ex[1] = 64'd110;
    i0 = 0;
    i1 = 0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    set0(1'b1, p0_s1[0], p0_s2[0], p0_op[0]);
    set1(1'b1, p1_s1[0], p1_s2[0], p1_op[0]);
    for (int s = 0; s < 4; s++) begin
      g = s % 2;
      #1;
      check($sformatf("rr%0d_req0_ready", s), req0_ready, (g == 0) ? 64'd1 : 64'd0);
      check($sformatf("rr%0d_req1_ready", s), req1_ready, (g == 1) ? 64'd1 : 64'd0);
      exp_res = (g == 0) ? p0_ex[i0] : p1_ex[i1];
      tick();
      check($sformatf("rr%0d_rsp0_valid", s), rsp0_valid, (g == 0) ? 64'd1 : 64'd0);
      check($sformatf("rr%0d_rsp1_valid", s), rsp1_valid, (g == 1) ? 64'd1 : 64'd0);
      check($sformatf("rr%0d_result", s), rsp_result, exp_res);
      if (g == 0) begin
        i0++;
        if (i0 < 2) set0(1'b1, p0_s1[i0], p0_s2[i0], p0_op[i0]);
        else req0_valid = 1'b0;
      end else begin
        i1++;
        if (i1 < 2) set1(1'b1, p1_s1[i1], p1_s2[i1], p1_op[i1]);
        else req1_valid = 1'b0;
      end
    end
    tick();
    check("rr_idle_rsp1_valid", rsp1_valid, 0);

    // Backpressure: port 0 result held while port 1 waits
    rsp0_ready = 1'b0;
    set0(1'b1, 64'd40, 64'd2, 2'b01);
    #1;
    check("bp_req0_ready", req0_ready, 1);
    tick();
    check("bp_rsp0_valid", rsp0_valid, 1);
    check("bp_result", rsp_result, 64'd42);
    req0_valid = 1'b0;
    set1(1'b1, 64'd1000, 64'd24, 2'b01);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bp%0d_req1_ready", c), req1_ready, 0);
      check($sformatf("bp%0d_result", c), rsp_result, 64'd42);
      check($sformatf("bp%0d_rsp0_valid", c), rsp0_valid, 1);
      tick();
    end
    rsp0_ready = 1'b1;
    #1;
    check("bp_release_req1_ready", req1_ready, 1);
    tick();
    check("bp_after_rsp1_valid", rsp1_valid, 1);
    check("bp_after_rsp0_valid", rsp0_valid, 0);
    check("bp_after_result", rsp_result, 64'd1024);
    req1_valid = 1'b0;
    rsp0_ready = 1'b0;

    // Async reset while port 0 holds a result (last becomes 0 before reset)
    set0(1'b1, 64'd3, 64'd4, 2'b01);
    tick();
    check("ar_rsp0_valid", rsp0_valid, 1);
    check("ar_result", rsp_result, 64'd7);
    req0_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_async_rsp0_valid", rsp0_valid, 0);
    check("ar_async_rsp1_valid", rsp1_valid, 0);
    check("ar_async_result", rsp_result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp0_ready = 1'b1;
    set0(1'b1, 64'd11, 64'd22, 2'b01);
    set1(1'b1, 64'd33, 64'd44, 2'b01);
    #1;
    check("ar_contest_req0_ready", req0_ready, 1);
    check("ar_contest_req1_ready", req1_ready, 0);
    tick();
    check("ar_contest_rsp0_valid", rsp0_valid, 1);
    check("ar_contest_result", rsp_result, 64'd33);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
